// File: rtl/mux_4to1.sv
// mux_4to1: four-lane selector with a zero-latency combinational output
// and a registered copy (enable-gated) carrying a one-cycle valid flag.
// Lane k lives at d[k*WIDTH +: WIDTH], lane 0 in the LSBs.
module mux_4to1 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4*WIDTH-1:0] d,
  input  logic [1:0]         sel,
  input  logic               en,
  output logic [WIDTH-1:0]   y,
  output logic [WIDTH-1:0]   y_q,
  output logic               vld_q
);

  // Combinational lane select; every sel code is covered so no latch forms,
  // and the path is independent of clk, en and rst_n.
  always_comb begin
    y = '0;
    case (sel)
      2'd0: y = d[0*WIDTH +: WIDTH];
      2'd1: y = d[1*WIDTH +: WIDTH];
      2'd2: y = d[2*WIDTH +: WIDTH];
      2'd3: y = d[3*WIDTH +: WIDTH];
      default: y = '0;
    endcase
  end

  // Registered copy: capture on en, hold otherwise; vld_q marks the edge
  // that updated y_q. Reset clears both without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= '0;
      vld_q <= 1'b0;
    end else if (en) begin
      y_q   <= y;
      vld_q <= 1'b1;
    end else begin
      vld_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_4to1.sv
// Bench for mux_4to1: one WIDTH=1 and one WIDTH=8 instance sharing clock
// and reset. Registered-path expectations go through a scoreboard queue.
module tb_mux_4to1;

  typedef struct packed {
    logic [7:0] yq;
    logic       vld;
  } exp_t;

  logic       clk = 1'b0;
  logic       clk_on = 1'b0;
  logic       rst_n;

  logic [3:0] d1;
  logic [1:0] sel1;
  logic       en1;
  logic       y1, yq1, vld1;

  logic [31:0] d8;
  logic [1:0]  sel8;
  logic        en8;
  logic [7:0]  y8, yq8;
  logic        vld8;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err = 0;

  logic [7:0] ref_yq8;
  logic [7:0] lane_exp;

  mux_4to1 #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .d(d1), .sel(sel1), .en(en1),
    .y(y1), .y_q(yq1), .vld_q(vld1)
  );

  mux_4to1 #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .d(d8), .sel(sel8), .en(en8),
    .y(y8), .y_q(yq8), .vld_q(vld8)
  );

  always #5 if (clk_on) clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [7:0] obs_yq, input logic obs_vld);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_yq"}, {56'b0, obs_yq}, {56'b0, e.yq});
      check({tag, "_vld"}, {63'b0, obs_vld}, {63'b0, e.vld});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lane8(input logic [31:0] dd, input logic [1:0] s);
    logic [31:0] sh;
    sh = dd >> (8 * int'(s));
    return sh[7:0];
  endfunction

  initial begin
    logic [3:0] exp1 [4];
    logic [7:0] exp8 [4];
    exp1[0] = 4'd0; exp1[1] = 4'd1; exp1[2] = 4'd0; exp1[3] = 4'd1;
    exp8[0] = 8'hAA; exp8[1] = 8'hBB; exp8[2] = 8'hCC; exp8[3] = 8'hDD;

    rst_n = 1'b1;
    d1 = '0; sel1 = '0; en1 = 1'b0;
    d8 = '0; sel8 = '0; en8 = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    check("rst_yq1", {63'b0, yq1}, 64'd0);
    check("rst_vld1", {63'b0, vld1}, 64'd0);
    check("rst_yq8", {56'b0, yq8}, 64'd0);
    check("rst_vld8", {63'b0, vld8}, 64'd0);
    rst_n = 1'b1;

    // combinational sweep, clock stopped
    d1 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      sel1 = 2'(i);
      #10;
      check("comb_w1", {63'b0, y1}, {60'b0, exp1[i]});
    end

    clk_on = 1'b1;
    tick();

    // capture then hold
    en1 = 1'b1; sel1 = 2'd3;
    sb.push_back('{yq: 8'd1, vld: 1'b1});
    tick();
    sb_check("cap_w1", {7'b0, yq1}, vld1);
    en1 = 1'b0; sel1 = 2'd0;
    sb.push_back('{yq: 8'd1, vld: 1'b0});
    tick();
    sb_check("hold_w1", {7'b0, yq1}, vld1);
    check("hold_y1", {63'b0, y1}, 64'd0);

    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    check("async_yq1", {63'b0, yq1}, 64'd0);
    check("async_vld1", {63'b0, vld1}, 64'd0);
    sel1 = 2'd1;
    #1;
    check("rst_comb_y1", {63'b0, y1}, 64'd1);

    // reset overrides en
    en1 = 1'b1; sel1 = 2'd3; en8 = 1'b1; d8 = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_en_yq1", {63'b0, yq1}, 64'd0);
      check("rst_en_vld1", {63'b0, vld1}, 64'd0);
      check("rst_en_vld8", {63'b0, vld8}, 64'd0);
    end
    en8 = 1'b0;
    rst_n = 1'b1;
    d1 = 4'b0100; sel1 = 2'd2; en1 = 1'b1;
    sb.push_back('{yq: 8'd1, vld: 1'b1});
    tick();
    sb_check("post_rst_w1", {7'b0, yq1}, vld1);
    en1 = 1'b0;
    ref_yq8 = 8'd0;
    check("post_rst_yq8", {56'b0, yq8}, 64'd0);

    // WIDTH=8 directed lane sequence
    d8 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    en8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel8 = 2'(i);
      #1;
      check("comb_w8", {56'b0, y8}, {56'b0, exp8[i]});
      sb.push_back('{yq: exp8[i], vld: 1'b1});
      ref_yq8 = exp8[i];
      tick();
      sb_check("seq_w8", yq8, vld8);
    end

    // random traffic against the reference model
    for (int c = 0; c < 1000; c++) begin
      d8   = $urandom;
      sel8 = 2'($urandom_range(0, 3));
      en8  = 1'($urandom_range(0, 1));
      #1;
      lane_exp = lane8(d8, sel8);
      check("rand_y8", {56'b0, y8}, {56'b0, lane_exp});
      if (en8) ref_yq8 = lane_exp;
      sb.push_back('{yq: ref_yq8, vld: en8});
      tick();
      sb_check("rand_w8", yq8, vld8);
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
